seg_scan_decoder: RTL

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_scan_decoder.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: rebuilds a 4-digit hex value by watching a multiplexed, active-low 7-segment scan.
// Latency: inputs are registered once; a digit is captured STABLE_CYCLES samples into a stable run, and valid follows one edge after the fourth capture.
// Backpressure: none; valid is a one-cycle pulse and value holds the last complete frame until the next one.
//
// Ports:
//   clk    - single clock, all state changes on its rising edge
//   rst    - synchronous, active-high reset
//   seg    - segment lines, active-low, {g,f,e,d,c,b,a}
//   an     - digit anodes, active-low, an[i] selects digit i (digit 0 least significant)
//   value  - reconstructed hex value, digit i in value[4i+3:4i]
//   valid  - one-cycle pulse when value has been refreshed with a complete frame
//   err    - sticky error flag (only active when SEGMON_ERR_EN is defined)
//
// Build option: define SEGMON_ERR_EN to include the illegal-pattern / multi-anode
// detector. Without it err is tied low and nothing else changes.

module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4  // consecutive identical samples to accept a digit, 2..255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] value,
  output logic        valid,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);

  // Sample stage and the previous sample used for run detection.
  logic [6:0]       seg_s;
  logic [3:0]       an_s;
  logic [6:0]       seg_p;
  logic [3:0]       an_p;

  state_t           state_q;
  state_t           state_d;
  logic [7:0]       count_q;
  logic [7:0]       count_d;
  logic [3:0]       mask_q;
  logic [3:0]       mask_d;
  logic [3:0][3:0]  digit_q;

  // Anode classification on the sampled pattern (inverted so a lit digit reads as 1).
  logic [3:0]       an_inv;
  logic             an_multi;
  logic             an_onehot;
  logic [1:0]       cap_idx;

  logic             sample_same;
  logic             count_at_lim;
  logic             stable_hit;
  logic             cap_en;
  logic             frame_done;

  logic [3:0]       dec_nib;
  logic             dec_legal;

  assign an_inv    = ~an_s;
  // Clearing the lowest set bit leaves something only if two or more digits are lit.
  assign an_multi  = |(an_inv & (an_inv - 4'd1));
  assign an_onehot = (an_inv != 4'd0) && !an_multi;

  always_comb begin
    cap_idx = 2'd0;
    case (an_inv)
      4'b0001: cap_idx = 2'd0;
      4'b0010: cap_idx = 2'd1;
      4'b0100: cap_idx = 2'd2;
      4'b1000: cap_idx = 2'd3;
      default: cap_idx = 2'd0;
    endcase
  end

  // Segment decode: active-low {g,f,e,d,c,b,a} to hex nibble.
  always_comb begin
    dec_nib   = 4'h0;
    dec_legal = 1'b1;
    case (seg_s)
      7'b1000000: dec_nib = 4'h0;
      7'b1111001: dec_nib = 4'h1;
      7'b0100100: dec_nib = 4'h2;
      7'b0110000: dec_nib = 4'h3;
      7'b0011001: dec_nib = 4'h4;
      7'b0010010: dec_nib = 4'h5;
      7'b0000010: dec_nib = 4'h6;
      7'b1111000: dec_nib = 4'h7;
      7'b0000000: dec_nib = 4'h8;
      7'b0010000: dec_nib = 4'h9;
      7'b0001000: dec_nib = 4'hA;
      7'b0000011: dec_nib = 4'hB;
      7'b1000110: dec_nib = 4'hC;
      7'b0100001: dec_nib = 4'hD;
      7'b0000110: dec_nib = 4'hE;
      7'b0001110: dec_nib = 4'hF;
      default: begin
        dec_nib   = 4'h0;
        dec_legal = 1'b0;
      end
    endcase
  end

  // The anode pattern takes part in the comparison: moving to another digit
  // with the same segments is a new run.
  assign sample_same  = ({seg_s, an_s} == {seg_p, an_p});
  // The count holds the run length seen so far; this sample completes the run.
  assign count_at_lim = (count_q >= (STABLE_LIM - 8'd1));
  assign stable_hit   = (state_q == SETTLE) && sample_same && count_at_lim;
  // SETTLE is only ever entered with a one-hot anode, so stable_hit implies one.
  assign cap_en       = stable_hit && dec_legal;
  assign frame_done   = (mask_q == 4'hF);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (an_onehot) begin
          state_d = SETTLE;
          count_d = 8'd1;
        end
      end
      SETTLE: begin
        if (sample_same) begin
          if (count_at_lim) begin
            // Legal or not, the digit is done; HOLD blocks a second capture of the same run.
            state_d = HOLD;
            count_d = STABLE_LIM;
          end else begin
            count_d = count_q + 8'd1;
          end
        end else begin
          count_d = 8'd1;
          state_d = an_onehot ? SETTLE : IDLE;
        end
      end
      HOLD: begin
        if (!sample_same) begin
          count_d = 8'd1;
          state_d = an_onehot ? SETTLE : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = 8'd0;
      end
    endcase
  end

  // A completed mask is cleared on the edge that publishes the frame; a capture
  // on that same edge would start the next frame.
  always_comb begin
    mask_d = frame_done ? 4'h0 : mask_q;
    if (cap_en) begin
      mask_d = mask_d | an_inv;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_s   <= 7'h7F;
      an_s    <= 4'hF;
      seg_p   <= 7'h7F;
      an_p    <= 4'hF;
      state_q <= IDLE;
      count_q <= 8'd0;
      mask_q  <= 4'h0;
      digit_q <= '0;
      value   <= 16'h0000;
      valid   <= 1'b0;
    end else begin
      seg_s   <= seg;
      an_s    <= an;
      seg_p   <= seg_s;
      an_p    <= an_s;
      state_q <= state_d;
      count_q <= count_d;
      mask_q  <= mask_d;
      // A recapture of a digit already in the mask simply overwrites it.
      if (cap_en) begin
        digit_q[cap_idx] <= dec_nib;
      end
      valid <= frame_done;
      if (frame_done) begin
        value <= digit_q;
      end
    end
  end

`ifdef SEGMON_ERR_EN
  // Sticky: an illegal pattern that stayed stable long enough, or several lit anodes.
  logic illegal_hit;

  assign illegal_hit = stable_hit && !dec_legal;

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (illegal_hit || an_multi) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
